// File: rtl/cpu_pio_write_arbiter_if.sv
// Bundle of requester-side and Avalon-MM PIO signals for cpu_pio_write_arbiter.
// master modport is the arbiter's view; slave modport is the requesters/PIO view.
interface cpu_pio_write_arbiter_if #(
   parameter int NREQ = 4,
   parameter int DW   = 4
);
   logic [NREQ-1:0]    req;
   logic [NREQ*DW-1:0] req_data;
   logic [NREQ-1:0]    gnt;
   logic               busy;
   logic [DW-1:0]      cur_value;
   logic               err;
   logic               err_clr;
   logic [1:0]         avm_address;
   logic               avm_chipselect;
   logic               avm_write_n;
   logic [31:0]        avm_writedata;
   logic [31:0]        avm_readdata;

   modport master (
      input  req, req_data, err_clr, avm_readdata,
      output gnt, busy, cur_value, err,
             avm_address, avm_chipselect, avm_write_n, avm_writedata
   );

   modport slave (
      output req, req_data, err_clr, avm_readdata,
      input  gnt, busy, cur_value, err,
             avm_address, avm_chipselect, avm_write_n, avm_writedata
   );
endinterface

// File: rtl/cpu_pio_write_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM output PIO between NREQ requesters.
// Define PIO_ARB_READBACK_EN to add a readback-compare cycle and the sticky err flag.
module cpu_pio_write_arbiter #(
   parameter int NREQ = 4,
   parameter int DW   = 4,
   parameter int ADDR = 0
) (
   input  logic                    clk,
   input  logic                    reset,
   cpu_pio_write_arbiter_if.master bus
);
   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_WRITE = 2'd1;
   localparam logic [1:0] ST_READ  = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   localparam logic [IW-1:0] LAST_RST = IW'(NREQ - 1);

   logic [1:0]      state_r;
   logic [IW-1:0]   last_r;
   logic [IW-1:0]   win_r;
   logic [DW-1:0]   data_r;
   logic [NREQ-1:0] gnt_r;
   logic            busy_r;
   logic [DW-1:0]   cur_r;
   logic            cs_r;
   logic            wn_r;
   logic [31:0]     wdata_r;
   logic            err_r;

   logic [IW-1:0]   pick_s;
   logic            found_s;
   logic [IW-1:0]   idx_s;
   logic            hit_s;
   logic [DW-1:0]   pick_data_s;
   logic            unused_s;

   function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] idx);
      return {{(NREQ-1){1'b0}}, 1'b1} << idx;
   endfunction

   // Round-robin search: first set req bit starting just above the last winner.
   always_comb begin
      pick_s  = last_r;
      found_s = 1'b0;
      idx_s   = last_r;
      hit_s   = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
         idx_s   = IW'((int'(last_r) + k) % NREQ);
         hit_s   = !found_s && bus.req[idx_s];
         pick_s  = hit_s ? idx_s : pick_s;
         found_s = found_s | hit_s;
      end
   end

   // Mux the selected requester's data slice.
   always_comb begin
      pick_data_s = '0;
      for (int i = 0; i < NREQ; i++) begin
         pick_data_s = (pick_s == IW'(i)) ? bus.req_data[i*DW +: DW] : pick_data_s;
      end
   end

   // Transaction FSM; all bus-facing outputs come straight from registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_IDLE;
         last_r  <= LAST_RST;
         win_r   <= '0;
         data_r  <= '0;
         gnt_r   <= '0;
         busy_r  <= 1'b0;
         cur_r   <= '0;
         cs_r    <= 1'b0;
         wn_r    <= 1'b1;
         wdata_r <= 32'd0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               gnt_r <= '0;
               if (found_s) begin
                  win_r   <= pick_s;
                  data_r  <= pick_data_s;
                  wdata_r <= 32'(pick_data_s);
                  cs_r    <= 1'b1;
                  wn_r    <= 1'b0;
                  busy_r  <= 1'b1;
                  state_r <= ST_WRITE;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_WRITE: begin
               cur_r <= data_r;
               wn_r  <= 1'b1;
`ifdef PIO_ARB_READBACK_EN
               state_r <= ST_READ;
`else
               cs_r    <= 1'b0;
               gnt_r   <= onehot(win_r);
               state_r <= ST_DONE;
`endif
            end
            ST_READ: begin
`ifdef PIO_ARB_READBACK_EN
               cs_r    <= 1'b0;
               gnt_r   <= onehot(win_r);
               state_r <= ST_DONE;
`else
               cs_r    <= 1'b0;
               state_r <= ST_IDLE;
`endif
            end
            ST_DONE: begin
               gnt_r   <= '0;
               busy_r  <= 1'b0;
               last_r  <= win_r;
               state_r <= ST_IDLE;
            end
            default: begin
               gnt_r   <= '0;
               busy_r  <= 1'b0;
               cs_r    <= 1'b0;
               wn_r    <= 1'b1;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef PIO_ARB_READBACK_EN
   // Sticky readback mismatch flag; a mismatch outranks a simultaneous clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         err_r <= 1'b0;
      end else if (state_r == ST_READ && bus.avm_readdata[DW-1:0] != data_r) begin
         err_r <= 1'b1;
      end else if (bus.err_clr) begin
         err_r <= 1'b0;
      end else begin
         err_r <= err_r;
      end
   end
`else
   assign err_r = 1'b0;
`endif

   assign unused_s = ^{bus.avm_readdata, bus.err_clr};

   assign bus.gnt            = gnt_r;
   assign bus.busy           = busy_r;
   assign bus.cur_value      = cur_r;
   assign bus.err            = err_r;
   assign bus.avm_address    = 2'(ADDR);
   assign bus.avm_chipselect = cs_r;
   assign bus.avm_write_n    = wn_r;
   assign bus.avm_writedata  = wdata_r;
endmodule

// File: tb/tb_cpu_pio_write_arbiter.sv
// Directed self-checking bench for cpu_pio_write_arbiter (NREQ=4, DW=4, ADDR=0).
// Inputs change and outputs are sampled on the falling edge.
module tb_cpu_pio_write_arbiter;
   logic        clk = 1'b0;
   logic        reset;
   logic        bad_rb = 1'b0;
   logic [31:0] pio_q = 32'd0;
   logic        err_exp = 1'b0;
   int          checks = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   cpu_pio_write_arbiter_if #(.NREQ(4), .DW(4)) bus ();

   cpu_pio_write_arbiter #(.NREQ(4), .DW(4), .ADDR(0)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // PIO slave model: latches writes; bad_rb forces a wrong readback value
   always @(posedge clk) begin
      if (bus.avm_chipselect && !bus.avm_write_n) pio_q <= bus.avm_writedata;
   end
   assign bus.avm_readdata = bad_rb ? 32'h5 : pio_q;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Entered on the falling edge before the IDLE edge that latches the request
   task automatic serve(input string tag, input logic [3:0] g, input logic [3:0] v, input logic e);
      @(negedge clk);
      chk({tag, ":wr_cs"},    32'(bus.avm_chipselect), 32'd1);
      chk({tag, ":wr_wn"},    32'(bus.avm_write_n),    32'd0);
      chk({tag, ":wr_data"},  bus.avm_writedata,       {28'd0, v});
      chk({tag, ":wr_addr"},  32'(bus.avm_address),    32'd0);
      chk({tag, ":wr_busy"},  32'(bus.busy),           32'd1);
      chk({tag, ":wr_gnt"},   32'(bus.gnt),            32'd0);
`ifdef PIO_ARB_READBACK_EN
      @(negedge clk);
      chk({tag, ":rd_cs"},    32'(bus.avm_chipselect), 32'd1);
      chk({tag, ":rd_wn"},    32'(bus.avm_write_n),    32'd1);
      chk({tag, ":rd_gnt"},   32'(bus.gnt),            32'd0);
`endif
      @(negedge clk);
      chk({tag, ":dn_gnt"},   32'(bus.gnt),            {28'd0, g});
      chk({tag, ":dn_cur"},   32'(bus.cur_value),      {28'd0, v});
      chk({tag, ":dn_cs"},    32'(bus.avm_chipselect), 32'd0);
      chk({tag, ":dn_wn"},    32'(bus.avm_write_n),    32'd1);
      chk({tag, ":dn_err"},   32'(bus.err),            32'(e));
   endtask

   task automatic gap(input string tag);
      @(negedge clk);
      chk({tag, ":idle_busy"}, 32'(bus.busy),           32'd0);
      chk({tag, ":idle_gnt"},  32'(bus.gnt),            32'd0);
      chk({tag, ":idle_cs"},   32'(bus.avm_chipselect), 32'd0);
      chk({tag, ":idle_err"},  32'(bus.err),            32'(err_exp));
   endtask

   initial begin
      reset = 1'b1;
      bus.req = 4'b0000;
      bus.req_data = 16'h0000;
      bus.err_clr = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_gnt",   32'(bus.gnt),            32'd0);
      chk("rst_busy",  32'(bus.busy),           32'd0);
      chk("rst_cur",   32'(bus.cur_value),      32'd0);
      chk("rst_err",   32'(bus.err),            32'd0);
      chk("rst_cs",    32'(bus.avm_chipselect), 32'd0);
      chk("rst_wn",    32'(bus.avm_write_n),    32'd1);
      chk("rst_addr",  32'(bus.avm_address),    32'd0);
      chk("rst_wdata", bus.avm_writedata,       32'd0);
      reset = 1'b0;

      // single write of 4'hA by requester 0
      bus.req = 4'b0001;
      bus.req_data = 16'h000A;
      serve("t1", 4'b0001, 4'hA, 1'b0);
      bus.req = 4'b0000;
      gap("t1");
      chk("t1_wdata_hold", bus.avm_writedata, 32'h0000_000A);

      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;

      // all four request; order 0,1,2,3 with one idle cycle between writes
      bus.req = 4'b1111;
      bus.req_data = 16'h4321;
      serve("t2_r0", 4'b0001, 4'h1, 1'b0);
      bus.req = 4'b1110;
      gap("t2_a");
      serve("t2_r1", 4'b0010, 4'h2, 1'b0);
      bus.req = 4'b1100;
      gap("t2_b");
      serve("t2_r2", 4'b0100, 4'h3, 1'b0);
      bus.req = 4'b1000;
      gap("t2_c");
      serve("t2_r3", 4'b1000, 4'h4, 1'b0);
      bus.req = 4'b0000;
      gap("t2_d");

      // requester 2 alone, kept high after gnt: served twice
      bus.req = 4'b0100;
      bus.req_data = 16'hC7B0;
      serve("t3_r2a", 4'b0100, 4'h7, 1'b0);
      gap("t3_a");
      bus.req_data = 16'hC9B0;
      serve("t3_r2b", 4'b0100, 4'h9, 1'b0);
      // 1 and 3 together after last winner 2: 3 first, then 1
      bus.req = 4'b1010;
      gap("t3_b");
      serve("t3_r3", 4'b1000, 4'hC, 1'b0);
      bus.req = 4'b0010;
      gap("t3_c");
      serve("t3_r1", 4'b0010, 4'hB, 1'b0);
      bus.req = 4'b0000;
      gap("t3_d");

      // reset during WRITE aborts with no gnt; pointer returns to requester 0 first
      bus.req = 4'b0001;
      bus.req_data = 16'h0005;
      @(negedge clk);
      chk("t4_in_write", 32'(bus.avm_chipselect), 32'd1);
      reset = 1'b1;
      bus.req = 4'b1001;
      bus.req_data = 16'hE005;
      @(negedge clk);
      chk("t4_abort_cs",   32'(bus.avm_chipselect), 32'd0);
      chk("t4_abort_busy", 32'(bus.busy),           32'd0);
      chk("t4_abort_gnt",  32'(bus.gnt),            32'd0);
      chk("t4_abort_wn",   32'(bus.avm_write_n),    32'd1);
      chk("t4_abort_cur",  32'(bus.cur_value),      32'd0);
      reset = 1'b0;
      serve("t4_r0", 4'b0001, 4'h5, 1'b0);
      bus.req = 4'b1000;
      gap("t4_a");
      serve("t4_r3", 4'b1000, 4'hE, 1'b0);
      bus.req = 4'b0000;
      gap("t4_b");

`ifdef PIO_ARB_READBACK_EN
      // wrong readback sets err at DONE; err_clr clears; good readback keeps it clear
      bad_rb = 1'b1;
      bus.req = 4'b0001;
      bus.req_data = 16'h0006;
      serve("t5_bad", 4'b0001, 4'h6, 1'b1);
      err_exp = 1'b1;
      bus.req = 4'b0000;
      bad_rb = 1'b0;
      gap("t5_a");
      bus.err_clr = 1'b1;
      @(negedge clk);
      chk("t5_clr", 32'(bus.err), 32'd0);
      bus.err_clr = 1'b0;
      err_exp = 1'b0;
      bus.req = 4'b0001;
      serve("t5_good", 4'b0001, 4'h6, 1'b0);
      bus.req = 4'b0000;
      gap("t5_b");
`endif

      // data and req change after latching are ignored; gnt still issued
      bus.req = 4'b0010;
      bus.req_data = 16'h0030;
      @(negedge clk);
      chk("t6_wr_data", bus.avm_writedata, 32'h0000_0003);
      chk("t6_wr_wn",   32'(bus.avm_write_n), 32'd0);
      bus.req = 4'b0000;
      bus.req_data = 16'h00F0;
`ifdef PIO_ARB_READBACK_EN
      @(negedge clk);
`endif
      @(negedge clk);
      chk("t6_gnt",   32'(bus.gnt),       32'd2);
      chk("t6_cur",   32'(bus.cur_value), 32'd3);
      chk("t6_wdata", bus.avm_writedata,  32'h0000_0003);
      gap("t6_a");
      gap("t6_b");
      chk("t6_cur_hold",   32'(bus.cur_value), 32'd3);
      chk("t6_wdata_hold", bus.avm_writedata,  32'h0000_0003);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
